// File: rtl/forwarding_control_unit.sv
// Forwarding/hazard control: shadows EX/MEM/WB destination info, drives ALU operand forward selects, load-use stall and EX bubble.
// Latency: outputs are combinational from registered slot state and current ID fields; slots advance every rising edge.
// Backpressure: Stall holds PC and IF/ID for one cycle on a load-use hazard; Bubble (Stall | Flush) loads a NOP into EX. Optional STALL_COUNTER_EN adds StallCount.
module forwarding_control_unit #(
  parameter int RegBits = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RegBits-1:0] ID_Rs,
  input  logic [RegBits-1:0] ID_Rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic [RegBits-1:0] ID_WriteReg,
  input  logic               Flush,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               Stall,
  output logic               Bubble
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]        StallCount
`endif
);

  typedef struct packed {
    logic [RegBits-1:0] rs;
    logic [RegBits-1:0] rt;
    logic               uses_rs;
    logic               uses_rt;
    logic               reg_write;
    logic               mem_read;
    logic [RegBits-1:0] wreg;
  } ex_slot_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic [RegBits-1:0] wreg;
  } mem_slot_t;

  typedef struct packed {
    logic               reg_write;
    logic [RegBits-1:0] wreg;
  } wb_slot_t;

  ex_slot_t  ex_q,  ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q,  wb_d;

  logic       stall;
  logic       bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Select source for one EX operand. A load sitting in MEM has no data yet,
  // so it is never a MEM-stage source; the load-use stall keeps that case from
  // arising, and the guard lets the older WB match be used instead.
  function automatic logic [1:0] fwd_sel(
    input logic               uses,
    input logic [RegBits-1:0] src,
    input mem_slot_t          mem,
    input wb_slot_t           wb
  );
    logic mem_hit;
    logic wb_hit;
    mem_hit = uses && mem.reg_write && !mem.mem_read &&
              (mem.wreg != '0) && (mem.wreg == src);
    wb_hit  = uses && wb.reg_write && (wb.wreg != '0) && (wb.wreg == src);
    if (mem_hit)     return 2'd1;
    else if (wb_hit) return 2'd2;
    else             return 2'd0;
  endfunction

  // Hazard detection and forwarding selects for the current cycle.
  always_comb begin
    stall  = ex_q.mem_read && ex_q.reg_write && (ex_q.wreg != '0) &&
             ((ID_UsesRs && (ID_Rs == ex_q.wreg)) ||
              (ID_UsesRt && (ID_Rt == ex_q.wreg)));
    bubble = stall || Flush;
    fwd_a  = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    fwd_b  = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
  end

  assign Stall    = stall;
  assign Bubble   = bubble;
  assign ForwardA = fwd_a;
  assign ForwardB = fwd_b;

  // Next state of the shadow pipeline: shift down, EX takes ID or a NOP.
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.rs        = ID_Rs;
      ex_d.rt        = ID_Rt;
      ex_d.uses_rs   = ID_UsesRs;
      ex_d.uses_rt   = ID_UsesRt;
      ex_d.reg_write = ID_RegWrite;
      ex_d.mem_read  = ID_MemRead;
      ex_d.wreg      = ID_WriteReg;
    end
    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;
    mem_d.wreg      = ex_q.wreg;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.wreg       = mem_q.wreg;
  end

  // Slot registers; reset empties every slot to a NOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Free-running count of stalled cycles; wraps naturally at 2^32.
  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall};
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Directed bench for forwarding_control_unit: hand-computed forwarding/stall vectors.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Optional STALL_COUNTER_EN also checks StallCount against a bench-side expected count.
module tb_forwarding_control_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, bubble;
`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_sc   = 0;

  forwarding_control_unit #(.RegBits(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_Rs       (id_rs),
    .ID_Rt       (id_rt),
    .ID_UsesRs   (id_uses_rs),
    .ID_UsesRt   (id_uses_rt),
    .ID_RegWrite (id_reg_write),
    .ID_MemRead  (id_mem_read),
    .ID_WriteReg (id_wreg),
    .Flush       (flush),
    .ForwardA    (fwd_a),
    .ForwardB    (fwd_b),
    .Stall       (stall),
    .Bubble      (bubble)
`ifdef STALL_COUNTER_EN
    ,
    .StallCount  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sc(input string tag);
`ifdef STALL_COUNTER_EN
    check(tag, stall_count, exp_sc);
`endif
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic rw, input logic mr, input logic [4:0] wr);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_wreg = wr;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  // Watchdog: the run is a fixed sequence, this only catches a stuck simulator.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    nop();
    #12;
    check("rst_fa", fwd_a, 0);
    check("rst_fb", fwd_b, 0);
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble, 0);
    check_sc("rst_sc");
    reset = 1'b1;
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5 -> MEM forward on A
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); #1;
    check("alu_stall0", stall, 0);
    tick();
    set_id(5'd3, 5'd5, 1, 1, 1, 0, 5'd4); #1;
    check("alu_stall1", stall, 0);
    tick();
    nop(); #1;
    check("alu_fa", fwd_a, 1);
    check("alu_fb", fwd_b, 0);
    check("alu_stall2", stall, 0);
    drain();

    // add $3 ; nop ; or $6,$3,$3 -> WB forward on both
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    nop(); tick();
    set_id(5'd3, 5'd3, 1, 1, 1, 0, 5'd6); tick();
    nop(); #1;
    check("wb_fa", fwd_a, 2);
    check("wb_fb", fwd_b, 2);
    drain();

    // add $3 ; add $3 ; or $7,$3,$0 -> MEM wins over WB
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    set_id(5'd3, 5'd0, 1, 1, 1, 0, 5'd7); tick();
    nop(); #1;
    check("prio_fa", fwd_a, 1);
    check("prio_fb", fwd_b, 0);
    drain();

    // add $3 ; nop ; nop ; use $3 -> register file supplies it
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    nop(); tick();
    nop(); tick();
    set_id(5'd3, 5'd3, 1, 1, 1, 0, 5'd6); tick();
    nop(); #1;
    check("far_fa", fwd_a, 0);
    check("far_fb", fwd_b, 0);
    drain();

    // lw $8,0($9) ; add $10,$8,$8 -> one stall then WB forward
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd8); #1;
    check("lu_stall0", stall, 0);
    tick();
    set_id(5'd8, 5'd8, 1, 1, 1, 0, 5'd10); #1;
    check("lu_stall1", stall, 1);
    check("lu_bubble1", bubble, 1);
    tick();
    exp_sc = 1;
    check("lu_stall2", stall, 0);
    check("lu_bubble2", bubble, 0);
    tick();
    nop(); #1;
    check("lu_fa", fwd_a, 2);
    check("lu_fb", fwd_b, 2);
    check_sc("lu_sc");
    drain();

    // lw $8 ; lw $11,0($8) ; add $12,$11,$0 -> one stall per pair
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd8); tick();
    set_id(5'd8, 5'd0, 1, 0, 1, 1, 5'd11); #1;
    check("ll_stall1", stall, 1);
    tick();
    check("ll_stall2", stall, 0);
    tick();
    set_id(5'd11, 5'd0, 1, 1, 1, 0, 5'd12); #1;
    check("ll_stall3", stall, 1);
    tick();
    check("ll_stall4", stall, 0);
    tick();
    nop(); #1;
    exp_sc = 3;
    check("ll_fa", fwd_a, 2);
    check("ll_fb", fwd_b, 0);
    check_sc("ll_sc");
    drain();

    // Register zero: add $0 ; or $5,$0,$0, then lw $0 ; use $0
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd0); tick();
    set_id(5'd0, 5'd0, 1, 1, 1, 0, 5'd5); #1;
    check("z_stall0", stall, 0);
    tick();
    nop(); #1;
    check("z_fa", fwd_a, 0);
    check("z_fb", fwd_b, 0);
    drain();
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd0); tick();
    set_id(5'd0, 5'd0, 1, 1, 1, 0, 5'd5); #1;
    check("zl_stall", stall, 0);
    check("zl_bubble", bubble, 0);
    tick();
    nop(); #1;
    check("zl_fa", fwd_a, 0);
    check("zl_fb", fwd_b, 0);
    drain();

    // Flush: addi $2 is dropped, later reader of $2 sees no forward
    set_id(5'd1, 5'd0, 1, 0, 1, 0, 5'd2);
    flush = 1'b1; #1;
    check("fl_bubble", bubble, 1);
    check("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    set_id(5'd2, 5'd2, 1, 1, 1, 0, 5'd4); tick();
    nop(); #1;
    check("fl_fa", fwd_a, 0);
    check("fl_fb", fwd_b, 0);
    drain();

    // Flush together with a load-use stall: both flags, still counted
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd8); tick();
    set_id(5'd8, 5'd8, 1, 1, 1, 0, 5'd10);
    flush = 1'b1; #1;
    check("fs_stall", stall, 1);
    check("fs_bubble", bubble, 1);
    tick();
    flush = 1'b0;
    exp_sc = 4;
    check_sc("fs_sc");
    drain();

    // Asynchronous reset in the middle of a stall
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd8); tick();
    set_id(5'd8, 5'd8, 1, 1, 1, 0, 5'd10); #1;
    check("ar_stall_pre", stall, 1);
    #1;
    reset = 1'b0;
    exp_sc = 0;
    #1;
    check("ar_stall", stall, 0);
    check("ar_bubble", bubble, 0);
    check("ar_fa", fwd_a, 0);
    check("ar_fb", fwd_b, 0);
    check_sc("ar_sc");
    tick();
    reset = 1'b1; #1;
    check("ar_stall_post", stall, 0);
    tick();
    nop(); #1;
    check("ar_fa_post", fwd_a, 0);
    check("ar_fb_post", fwd_b, 0);
    drain();
    set_id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    set_id(5'd3, 5'd5, 1, 1, 1, 0, 5'd4); tick();
    nop(); #1;
    check("ar_pair_fa", fwd_a, 1);
    check("ar_pair_fb", fwd_b, 0);
    drain();
    set_id(5'd9, 5'd0, 1, 0, 1, 1, 5'd8); tick();
    set_id(5'd8, 5'd8, 1, 1, 1, 0, 5'd10); #1;
    check("ar_lu_stall", stall, 1);
    tick();
    exp_sc = 1;
    check_sc("ar_lu_sc");
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
